// File: rtl/jtag_pkg.sv
// Shared TAP state encoding and default opcodes/ID for the soft JTAG register bridge.
package jtag_pkg;

  typedef enum logic [3:0] {
    TLR    = 4'd0,
    RTI    = 4'd1,
    SEL_DR = 4'd2,
    CAP_DR = 4'd3,
    SH_DR  = 4'd4,
    EX1_DR = 4'd5,
    PAU_DR = 4'd6,
    EX2_DR = 4'd7,
    UPD_DR = 4'd8,
    SEL_IR = 4'd9,
    CAP_IR = 4'd10,
    SH_IR  = 4'd11,
    EX1_IR = 4'd12,
    PAU_IR = 4'd13,
    EX2_IR = 4'd14,
    UPD_IR = 4'd15
  } tap_state_e;

  localparam logic [3:0]  DEF_IR_IDCODE = 4'h1;
  localparam logic [3:0]  DEF_IR_USER   = 4'h2;
  localparam logic [31:0] DEF_IDCODE    = 32'h0000_0001;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller advanced by synchronised TCK rising pulses.
// Action flags are single-cycle strobes aligned with the tck_rise that performs them.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tck_rise,
  input  logic       tms,
  output tap_state_e state,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       update_ir
);

  tap_state_e state_next;

  // State register, stepped only on TCK rising pulses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= TLR;
    end else if (tck_rise) begin
      state <= state_next;
    end else begin
      state <= state;
    end
  end

  // Next-state decode and action strobes; updates fire on entry to the Update states
  always_comb begin
    state_next = state;
    case (state)
      TLR:     state_next = tms ? TLR    : RTI;
      RTI:     state_next = tms ? SEL_DR : RTI;
      SEL_DR:  state_next = tms ? SEL_IR : CAP_DR;
      CAP_DR:  state_next = tms ? EX1_DR : SH_DR;
      SH_DR:   state_next = tms ? EX1_DR : SH_DR;
      EX1_DR:  state_next = tms ? UPD_DR : PAU_DR;
      PAU_DR:  state_next = tms ? EX2_DR : PAU_DR;
      EX2_DR:  state_next = tms ? UPD_DR : SH_DR;
      UPD_DR:  state_next = tms ? SEL_DR : RTI;
      SEL_IR:  state_next = tms ? TLR    : CAP_IR;
      CAP_IR:  state_next = tms ? EX1_IR : SH_IR;
      SH_IR:   state_next = tms ? EX1_IR : SH_IR;
      EX1_IR:  state_next = tms ? UPD_IR : PAU_IR;
      PAU_IR:  state_next = tms ? EX2_IR : PAU_IR;
      EX2_IR:  state_next = tms ? UPD_IR : SH_IR;
      UPD_IR:  state_next = tms ? SEL_DR : RTI;
      default: state_next = TLR;
    endcase
    capture_dr = tck_rise && (state == CAP_DR);
    shift_dr   = tck_rise && (state == SH_DR);
    update_dr  = tck_rise && (state_next == UPD_DR) && (state != UPD_DR);
    capture_ir = tck_rise && (state == CAP_IR);
    shift_ir   = tck_rise && (state == SH_IR);
    update_ir  = tck_rise && (state_next == UPD_IR) && (state != UPD_IR);
  end

endmodule

// File: rtl/jtag_reg_bridge.sv
// Soft JTAG TAP oversampled in clk_i, with IDCODE, BYPASS and an {addr,data} USER
// register that writes into the core through a single-cycle update strobe.
module jtag_reg_bridge
  import jtag_pkg::*;
#(
  parameter int                     DATA_WIDTH   = 8,
  parameter int                     ADDR_WIDTH   = 3,
  parameter int                     IR_WIDTH     = 4,
  parameter logic [31:0]            IDCODE_VALUE = DEF_IDCODE,
  parameter logic [IR_WIDTH-1:0]    IR_IDCODE    = IR_WIDTH'(DEF_IR_IDCODE),
  parameter logic [IR_WIDTH-1:0]    IR_USER      = IR_WIDTH'(DEF_IR_USER)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  jtag_tck,
  input  logic                  jtag_tms,
  input  logic                  jtag_tdi,
  output logic                  jtag_tdo,
  input  logic [DATA_WIDTH-1:0] reg_d,
  input  logic [ADDR_WIDTH-1:0] reg_addr_d,
  output logic                  reg_update,
  output logic [DATA_WIDTH-1:0] reg_q,
  output logic [ADDR_WIDTH-1:0] reg_addr_q,
  output logic                  jrstn
);

  localparam int UW = ADDR_WIDTH + DATA_WIDTH;

  logic [2:0]          tck_sync;
  logic [1:0]          tms_sync;
  logic [1:0]          tdi_sync;
  logic                tck_rise;
  logic                tck_fall;
  logic [IR_WIDTH-1:0] ir;
  logic [IR_WIDTH-1:0] ir_sr;
  logic [31:0]         idcode_sr;
  logic [UW-1:0]       user_sr;
  logic                bypass_sr;
  logic                sel_idcode;
  logic                sel_user;
  logic                dr_lsb;
  logic                tdo_next;
  tap_state_e          state;
  logic                capture_dr, shift_dr, update_dr;
  logic                capture_ir, shift_ir, update_ir;

  assign tck_rise   = tck_sync[1] & ~tck_sync[2];
  assign tck_fall   = ~tck_sync[1] & tck_sync[2];
  assign sel_idcode = (ir == IR_IDCODE);
  assign sel_user   = (ir == IR_USER) && !sel_idcode;

  jtag_tap_fsm u_fsm (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .tck_rise   (tck_rise),
    .tms        (tms_sync[1]),
    .state      (state),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr),
    .capture_ir (capture_ir),
    .shift_ir   (shift_ir),
    .update_ir  (update_ir)
  );

  // Pin synchronisers; TCK carries an extra stage for edge detection
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tck_sync <= 3'b000;
      tms_sync <= 2'b00;
      tdi_sync <= 2'b00;
    end else begin
      tck_sync <= {tck_sync[1:0], jtag_tck};
      tms_sync <= {tms_sync[0], jtag_tms};
      tdi_sync <= {tdi_sync[0], jtag_tdi};
    end
  end

  // Instruction register and its shift stage
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ir    <= IR_IDCODE;
      ir_sr <= '0;
    end else begin
      if (state == TLR)   ir <= IR_IDCODE;
      else if (update_ir) ir <= ir_sr;
      if (capture_ir)     ir_sr <= {{(IR_WIDTH-1){1'b0}}, 1'b1};
      else if (shift_ir)  ir_sr <= {tdi_sync[1], ir_sr[IR_WIDTH-1:1]};
    end
  end

  // Data registers: only the one selected by the current IR captures or shifts
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idcode_sr <= 32'h0000_0000;
      user_sr   <= '0;
      bypass_sr <= 1'b0;
    end else if (capture_dr) begin
      if (sel_idcode)    idcode_sr <= IDCODE_VALUE;
      else if (sel_user) user_sr   <= {reg_addr_d, reg_d};
      else               bypass_sr <= 1'b0;
    end else if (shift_dr) begin
      if (sel_idcode)    idcode_sr <= {tdi_sync[1], idcode_sr[31:1]};
      else if (sel_user) user_sr   <= {tdi_sync[1], user_sr[UW-1:1]};
      else               bypass_sr <= tdi_sync[1];
    end
  end

  // TDO source: LSB of whichever register is being shifted
  always_comb begin
    dr_lsb   = sel_idcode ? idcode_sr[0] : (sel_user ? user_sr[0] : bypass_sr);
    tdo_next = 1'b0;
    if (state == SH_IR)      tdo_next = ir_sr[0];
    else if (state == SH_DR) tdo_next = dr_lsb;
    else                     tdo_next = 1'b0;
  end

  // Registered outputs toward the pin and the core
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      jtag_tdo   <= 1'b0;
      reg_update <= 1'b0;
      reg_q      <= '0;
      reg_addr_q <= '0;
      jrstn      <= 1'b0;
    end else begin
      jrstn      <= (state != TLR);
      reg_update <= update_dr && sel_user;
      if (update_dr && sel_user) begin
        reg_q      <= user_sr[DATA_WIDTH-1:0];
        reg_addr_q <= user_sr[UW-1:DATA_WIDTH];
      end
      if (tck_fall) jtag_tdo <= tdo_next;
    end
  end

endmodule

// File: tb/tb_jtag_reg_bridge.sv
// Directed bench for jtag_reg_bridge: bit-bangs TCK/TMS/TDI and checks scans and strobes.
module tb_jtag_reg_bridge;

  logic       clk_i      = 1'b0;
  logic       rst_i      = 1'b1;
  logic       jtag_tck   = 1'b0;
  logic       jtag_tms   = 1'b1;
  logic       jtag_tdi   = 1'b0;
  logic       jtag_tdo;
  logic [7:0] reg_d      = 8'h00;
  logic [2:0] reg_addr_d = 3'd0;
  logic       reg_update;
  logic [7:0] reg_q;
  logic [2:0] reg_addr_q;
  logic       jrstn;

  int total   = 0;
  int bad     = 0;
  int upd_cnt = 0;

  jtag_reg_bridge dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .jtag_tck   (jtag_tck),
    .jtag_tms   (jtag_tms),
    .jtag_tdi   (jtag_tdi),
    .jtag_tdo   (jtag_tdo),
    .reg_d      (reg_d),
    .reg_addr_d (reg_addr_d),
    .reg_update (reg_update),
    .reg_q      (reg_q),
    .reg_addr_q (reg_addr_q),
    .jrstn      (jrstn)
  );

  always #5 clk_i = ~clk_i;

  // Number of clk_i cycles the update strobe has been high
  always @(negedge clk_i) if (reg_update) upd_cnt <= upd_cnt + 1;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // One TCK period of 8 clk_i; TDO is sampled just before the rising edge
  task automatic tck_pulse(input logic tms, input logic tdi, output logic tdo);
    jtag_tms = tms;
    jtag_tdi = tdi;
    wait_clk(4);
    tdo = jtag_tdo;
    jtag_tck = 1'b1;
    wait_clk(4);
    jtag_tck = 1'b0;
  endtask

  task automatic tck_step(input logic tms);
    logic d;
    tck_pulse(tms, 1'b0, d);
  endtask

  // From Run-Test/Idle: load an opcode, return the captured IR bits, end in Run-Test/Idle
  task automatic load_ir(input logic [3:0] op, output logic [3:0] cap);
    logic b;
    tck_step(1'b1); tck_step(1'b1); tck_step(1'b0); tck_step(1'b0);
    for (int i = 0; i < 4; i++) begin
      tck_pulse(i == 3, op[i], b);
      cap[i] = b;
    end
    tck_step(1'b1); tck_step(1'b0);
    wait_clk(4);
  endtask

  // From Run-Test/Idle: capture, shift n bits LSB first, pass Update-DR, end in Run-Test/Idle
  task automatic scan_dr(input int n, input logic [31:0] din, output logic [31:0] dout);
    logic b;
    dout = 32'h0;
    tck_step(1'b1); tck_step(1'b0); tck_step(1'b0);
    for (int i = 0; i < n; i++) begin
      tck_pulse(i == n - 1, din[i], b);
      dout[i] = b;
    end
    tck_step(1'b1); tck_step(1'b0);
    wait_clk(4);
  endtask

  task automatic test_reset;
    wait_clk(3);
    total++; if (jtag_tdo !== 1'b0)   begin bad++; $display("FAIL reset_tdo: got %b want 0", jtag_tdo); end
    total++; if (reg_update !== 1'b0) begin bad++; $display("FAIL reset_update: got %b want 0", reg_update); end
    total++; if (reg_q !== 8'h00)     begin bad++; $display("FAIL reset_reg_q: got %h want 00", reg_q); end
    total++; if (reg_addr_q !== 3'd0) begin bad++; $display("FAIL reset_addr_q: got %h want 0", reg_addr_q); end
    total++; if (jrstn !== 1'b0)      begin bad++; $display("FAIL reset_jrstn: got %b want 0", jrstn); end
    rst_i = 1'b0;
    wait_clk(2);
  endtask

  task automatic test_idcode;
    logic [31:0] dout;
    int u0;
    tck_step(1'b0);
    wait_clk(4);
    total++; if (jrstn !== 1'b1) begin bad++; $display("FAIL idcode_jrstn: got %b want 1", jrstn); end
    u0 = upd_cnt;
    scan_dr(32, 32'hFFFF_FFFF, dout);
    total++; if (dout !== 32'h0000_0001) begin bad++; $display("FAIL idcode_value: got %h want 00000001", dout); end
    total++; if (upd_cnt - u0 !== 0) begin bad++; $display("FAIL idcode_no_update: got %0d want 0", upd_cnt - u0); end
  endtask

  task automatic test_tlr_by_tms;
    logic [3:0]  cap;
    logic [31:0] dout;
    load_ir(4'h2, cap);
    total++; if (cap !== 4'b0001) begin bad++; $display("FAIL ir_capture: got %b want 0001", cap); end
    tck_step(1'b1); tck_step(1'b0); tck_step(1'b0); tck_step(1'b0); tck_step(1'b0);
    for (int i = 0; i < 5; i++) tck_step(1'b1);
    wait_clk(4);
    total++; if (jrstn !== 1'b0) begin bad++; $display("FAIL tlr_jrstn: got %b want 0", jrstn); end
    tck_step(1'b0);
    scan_dr(32, 32'h0, dout);
    total++; if (dout !== 32'h0000_0001) begin bad++; $display("FAIL tlr_ir_idcode: got %h want 00000001", dout); end
  endtask

  task automatic test_bypass;
    logic [3:0]  cap;
    logic [31:0] dout;
    int u0;
    load_ir(4'hF, cap);
    u0 = upd_cnt;
    scan_dr(8, 32'h0000_00C3, dout);
    total++; if (dout[7:0] !== 8'h86) begin bad++; $display("FAIL bypass_echo: got %h want 86", dout[7:0]); end
    total++; if (upd_cnt - u0 !== 0) begin bad++; $display("FAIL bypass_no_update: got %0d want 0", upd_cnt - u0); end
  endtask

  task automatic test_user_write;
    logic [3:0]  cap;
    logic [31:0] dout;
    int u0;
    reg_d = 8'h00; reg_addr_d = 3'd0;
    load_ir(4'h2, cap);
    u0 = upd_cnt;
    scan_dr(11, {21'd0, 3'd5, 8'hA5}, dout);
    total++; if (dout[10:0] !== 11'h000) begin bad++; $display("FAIL write_capture: got %h want 000", dout[10:0]); end
    total++; if (upd_cnt - u0 !== 1) begin bad++; $display("FAIL write_strobe: got %0d cycles want 1", upd_cnt - u0); end
    total++; if (reg_q !== 8'hA5) begin bad++; $display("FAIL write_reg_q: got %h want a5", reg_q); end
    total++; if (reg_addr_q !== 3'd5) begin bad++; $display("FAIL write_addr_q: got %h want 5", reg_addr_q); end
  endtask

  task automatic test_user_read;
    logic [31:0] dout;
    int u0;
    reg_d = 8'h3C; reg_addr_d = 3'd2;
    u0 = upd_cnt;
    scan_dr(11, {21'd0, 3'd7, 8'h81}, dout);
    total++; if (dout[10:0] !== 11'h23C) begin bad++; $display("FAIL read_capture: got %h want 23c", dout[10:0]); end
    total++; if (upd_cnt - u0 !== 1) begin bad++; $display("FAIL read_strobe: got %0d cycles want 1", upd_cnt - u0); end
    total++; if (reg_q !== 8'h81) begin bad++; $display("FAIL read_reg_q: got %h want 81", reg_q); end
    total++; if (reg_addr_q !== 3'd7) begin bad++; $display("FAIL read_addr_q: got %h want 7", reg_addr_q); end
  endtask

  task automatic test_hold;
    logic [3:0]  cap;
    logic [31:0] dout;
    int u0;
    load_ir(4'h1, cap);
    u0 = upd_cnt;
    scan_dr(32, 32'h1234_5678, dout);
    total++; if (dout !== 32'h0000_0001) begin bad++; $display("FAIL hold_idcode: got %h want 00000001", dout); end
    total++; if (upd_cnt - u0 !== 0) begin bad++; $display("FAIL hold_no_update: got %0d want 0", upd_cnt - u0); end
    total++; if (reg_q !== 8'h81) begin bad++; $display("FAIL hold_reg_q: got %h want 81", reg_q); end
    total++; if (reg_addr_q !== 3'd7) begin bad++; $display("FAIL hold_addr_q: got %h want 7", reg_addr_q); end
  endtask

  task automatic test_reset_mid_scan;
    logic [3:0]  cap;
    logic [31:0] dout;
    logic        b;
    int u0;
    load_ir(4'h2, cap);
    tck_step(1'b1); tck_step(1'b0); tck_step(1'b0);
    u0 = upd_cnt;
    for (int i = 0; i < 4; i++) tck_pulse(1'b0, 1'b1, b);
    wait_clk(1);
    rst_i = 1'b1;
    wait_clk(2);
    rst_i = 1'b0;
    wait_clk(2);
    total++; if (upd_cnt - u0 !== 0) begin bad++; $display("FAIL abort_no_update: got %0d want 0", upd_cnt - u0); end
    total++; if (reg_q !== 8'h00) begin bad++; $display("FAIL abort_reg_q: got %h want 00", reg_q); end
    total++; if (reg_addr_q !== 3'd0) begin bad++; $display("FAIL abort_addr_q: got %h want 0", reg_addr_q); end
    total++; if (jrstn !== 1'b0) begin bad++; $display("FAIL abort_jrstn: got %b want 0", jrstn); end
    tck_step(1'b0);
    scan_dr(32, 32'h0, dout);
    total++; if (dout !== 32'h0000_0001) begin bad++; $display("FAIL abort_tlr_idcode: got %h want 00000001", dout); end
    load_ir(4'h2, cap);
    u0 = upd_cnt;
    scan_dr(11, {21'd0, 3'd3, 8'h5A}, dout);
    total++; if (dout[10:0] !== 11'h23C) begin bad++; $display("FAIL rewrite_capture: got %h want 23c", dout[10:0]); end
    total++; if (upd_cnt - u0 !== 1) begin bad++; $display("FAIL rewrite_strobe: got %0d cycles want 1", upd_cnt - u0); end
    total++; if (reg_q !== 8'h5A) begin bad++; $display("FAIL rewrite_reg_q: got %h want 5a", reg_q); end
    total++; if (reg_addr_q !== 3'd3) begin bad++; $display("FAIL rewrite_addr_q: got %h want 3", reg_addr_q); end
  endtask

  initial begin
    test_reset;
    test_idcode;
    test_tlr_by_tms;
    test_bypass;
    test_user_write;
    test_user_read;
    test_hold;
    test_reset_mid_scan;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
